vec_normaliser: RTL and testbench

- Parametrised N-channel fixed-point vector normaliser; successor to the 4-component quaternion normaliser.
- Accepts one signed Q(INT.FRACT) vector per handshake and computes the sum of squares serially.
- Derives 1/sqrt by seeded Newton-Raphson, rescales each channel, and returns the unit vector.
- Sits between the Madgwick update stage and quaternion/vector consumers; also used for accel and mag normalisation (CHANNELS=3).

---
 rtl/vec_normaliser.sv | 162 ++++++++++++++++
 tb/tb_vec_normaliser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vec_normaliser.sv
// N-channel fixed-point vector normaliser: serial sum of squares, seeded Newton-Raphson
// reciprocal square root, then per-channel rescale. One vector in flight at a time.
module vec_normaliser #(
    parameter int CHANNELS        = 4,
    parameter int INT_WIDTH       = 2,
    parameter int FRACT_WIDTH     = 14,
    parameter int ISQ_FRACT_WIDTH = 20,
    parameter int NR_ITERS        = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [CHANNELS*(INT_WIDTH+FRACT_WIDTH)-1:0]      in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [CHANNELS*(INT_WIDTH+FRACT_WIDTH)-1:0]      out_data,
    output logic                                             out_zero
);
    localparam int W   = INT_WIDTH + FRACT_WIDTH;
    localparam int IW  = $clog2(CHANNELS);
    localparam int AW  = 2*W + IW;
    localparam int ISQ = ISQ_FRACT_WIDTH;
    localparam int YW  = FRACT_WIDTH + 1 + ISQ;
    localparam int TW  = 2*YW;
    localparam int NW  = $clog2(NR_ITERS + 1);
    localparam int RW  = W + YW + 2;

    localparam logic [YW-1:0]        THREE   = YW'(3) << ISQ;
    localparam logic signed [RW-1:0] HALF    = RW'(2**(ISQ-1));
    localparam logic signed [RW-1:0] HALF_M1 = HALF - RW'(1);
    localparam logic signed [RW-1:0] SMAX    = RW'(2**(W-1) - 1);
    localparam logic signed [RW-1:0] SMIN    = -SMAX - RW'(1);

    typedef enum logic [2:0] {IDLE, ACC, SEED, NR, SCALE, DONE} state_t;

    state_t                     state_q;
    logic                       in_ready_q, out_valid_q, out_zero_q;
    logic [CHANNELS-1:0][W-1:0] in_q, out_q;
    logic [AW-1:0]              acc_q;
    logic [YW-1:0]              y_q;
    logic [TW-1:0]              t_q;
    logic [IW-1:0]              idx_q;
    logic [1:0]                 ph_q;
    logic [NW-1:0]              it_q;

    // Element 0 lives in the MSB slot, so the channel index counts from the top.
    logic [IW-1:0]          slot;
    logic signed [W-1:0]    elem;
    logic signed [2*W-1:0]  sq;
    assign slot = IW'(CHANNELS-1) - idx_q;
    assign elem = in_q[slot];
    assign sq   = elem * elem;

    logic [YW-1:0] y0_d;
    always_comb begin : seed_c
        int p, ev, sh;
        p = 0;
        for (int i = 0; i < AW; i++) if (acc_q[i]) p = i;
        ev = p - 2*FRACT_WIDTH;
        sh = ISQ - (ev >>> 1);
        if (sh >= YW)    y0_d = '1;
        else if (sh < 0) y0_d = YW'(1);
        else             y0_d = YW'(1) << sh;
    end

    logic [TW-1:0]    ysq_d, yf_full, yf_sh;
    logic [AW+TW-1:0] at_full, at_sh;
    logic [YW-1:0]    t_d, f, y_nr, y_d;
    assign ysq_d   = TW'(y_q) * TW'(y_q);
    assign at_full = (AW+TW)'(acc_q) * (AW+TW)'(t_q);
    assign at_sh   = at_full >> (2*FRACT_WIDTH + ISQ);
    assign t_d     = (|at_sh[AW+TW-1:YW]) ? '1 : at_sh[YW-1:0];
    assign f       = THREE - t_q[YW-1:0];
    assign yf_full = TW'(y_q) * TW'(f);
    assign yf_sh   = yf_full >> (ISQ + 1);
    assign y_nr    = (|yf_sh[TW-1:YW]) ? '1 : yf_sh[YW-1:0];
    // A seed that lands with acc*y^2 >= 3 is outside the NR basin; halving y pulls it back in.
    assign y_d     = (t_q[YW-1:0] >= THREE) ? (y_q >> 1) : y_nr;

    logic signed [RW-1:0] sprod, srnd, sshift;
    logic [W-1:0]         r_d;
    assign sprod  = RW'(elem) * RW'($signed({1'b0, y_q}));
    assign srnd   = sprod + (sprod[RW-1] ? HALF_M1 : HALF);
    assign sshift = srnd >>> ISQ;
    assign r_d    = (sshift > SMAX) ? SMAX[W-1:0] :
                    (sshift < SMIN) ? SMIN[W-1:0] : sshift[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_q       <= '0;
            in_q        <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            t_q         <= '0;
            idx_q       <= '0;
            ph_q        <= '0;
            it_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid && in_ready_q) begin
                    in_q       <= in_data;
                    acc_q      <= '0;
                    idx_q      <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= ACC;
                end
                ACC: begin
                    acc_q <= acc_q + AW'($unsigned(sq));
                    if (idx_q == IW'(CHANNELS-1)) begin
                        idx_q   <= '0;
                        state_q <= SEED;
                    end else idx_q <= idx_q + 1'b1;
                end
                SEED: if (acc_q == '0) begin
                    out_q      <= '0;
                    out_zero_q <= 1'b1;
                    state_q    <= DONE;
                end else begin
                    y_q     <= y0_d;
                    ph_q    <= '0;
                    it_q    <= '0;
                    state_q <= NR;
                end
                NR: case (ph_q)
                    2'd0: begin t_q <= ysq_d;     ph_q <= 2'd1; end
                    2'd1: begin t_q <= TW'(t_d);  ph_q <= 2'd2; end
                    default: begin
                        y_q  <= y_d;
                        ph_q <= 2'd0;
                        if (it_q == NW'(NR_ITERS-1)) begin
                            idx_q   <= '0;
                            state_q <= SCALE;
                        end else it_q <= it_q + 1'b1;
                    end
                endcase
                SCALE: begin
                    out_q[slot] <= r_d;
                    if (idx_q == IW'(CHANNELS-1)) begin
                        out_zero_q <= 1'b0;
                        state_q    <= DONE;
                    end else idx_q <= idx_q + 1'b1;
                end
                DONE: if (out_valid_q && out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end else out_valid_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_vec_normaliser.sv
// Directed bench for vec_normaliser: vector table on a 4-channel build, handshake and
// reset corner sequences, and one vector through a 3-channel build.
module tb_vec_normaliser;
    localparam int LAT_NZ = 2*4 + 3*4 + 2;
    localparam int LAT_Z  = 4 + 2;
    localparam int LAT3   = 2*3 + 3*4 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [63:0] in_data, out_data;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, out_zero3;
    logic [47:0] in_data3, out_data3;

    int tests = 0;
    int fails = 0;

    vec_normaliser dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
    );

    vec_normaliser #(.CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_zero(out_zero3)
    );

    typedef struct {
        logic [63:0] vin;
        logic [63:0] vexp;
        logic        zexp;
        int          lat;
        string       name;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        tests++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int el4(input logic [63:0] v, input int i);
        return int'($signed(v[(3-i)*16 +: 16]));
    endfunction

    function automatic int el3(input logic [47:0] v, input int i);
        return int'($signed(v[(2-i)*16 +: 16]));
    endfunction

    task automatic run4(input logic [63:0] v, output logic [63:0] r, output logic z, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        r = out_data;
        z = out_zero;
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r, snap;
        logic        z;
        int          lat, bad, g;

        tbl[0] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, LAT_NZ, "identity"};
        tbl[1] = '{64'h2000_2000_2000_2000, 64'h2000_2000_2000_2000, 1'b0, LAT_NZ, "equal"};
        tbl[2] = '{64'h2000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, LAT_NZ, "subunit"};
        tbl[3] = '{64'hD000_4000_0000_0000, 64'hD99A_3333_0000_0000, 1'b0, LAT_NZ, "signed"};
        tbl[4] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, LAT_Z,  "zero"};
        tbl[5] = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, LAT_NZ, "after_zero"};
        tbl[6] = '{64'h0000_0000_0000_C000, 64'h0000_0000_0000_C000, 1'b0, LAT_NZ, "neg_last"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_out_data_zero", int'(out_data == '0), 1, 0);
        chk("rst_out_zero", int'(out_zero), 0, 0);
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run4(tbl[k].vin, r, z, lat);
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_e%0d", tbl[k].name, i), el4(r, i), el4(tbl[k].vexp, i), 1);
            chk({tbl[k].name, "_zero"}, int'(z), int'(tbl[k].zexp), 0);
            chk({tbl[k].name, "_lat"}, lat, tbl[k].lat, 0);
        end

        // Backpressure: result must hold and a stray in_valid must be ignored.
        @(negedge clk);
        in_data = 64'hD000_4000_0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 100) begin @(posedge clk); #1; g++; end
        chk("bp_lat", g, LAT_NZ, 0);
        snap = out_data;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin in_data = 64'h4000_0000_0000_0000; in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) bad++;
        end
        chk("bp_hold_cycles_bad", bad, 0, 0);
        chk("bp_e0", el4(snap, 0), -9830, 1);
        chk("bp_e1", el4(snap, 1), 13107, 1);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", int'(out_valid), 0, 0);
        chk("bp_ready_rise", int'(in_ready), 1, 0);
        @(negedge clk) out_ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("bp_no_accept", int'(out_valid), 0, 0);

        // Reset in the middle of the NR phase.
        @(negedge clk);
        in_data = 64'h4000_0000_0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_nr_in_ready", int'(in_ready), 1, 0);
        chk("rst_nr_out_valid", int'(out_valid), 0, 0);
        chk("rst_nr_out_data_zero", int'(out_data == '0), 1, 0);
        @(negedge clk) rst = 1'b0;
        run4(64'hD000_4000_0000_0000, r, z, lat);
        chk("post_rst_e0", el4(r, 0), -9830, 1);
        chk("post_rst_e1", el4(r, 1), 13107, 1);
        chk("post_rst_zero", int'(z), 0, 0);
        chk("post_rst_lat", lat, LAT_NZ, 0);

        // Three-channel build.
        @(negedge clk);
        in_data3 = {16'h3000, 16'h4000, 16'h0000};
        in_valid3 = 1'b1;
        @(posedge clk);
        #1 in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("ch3_e0", el3(out_data3, 0), 16'h2666, 1);
        chk("ch3_e1", el3(out_data3, 1), 16'h3333, 1);
        chk("ch3_e2", el3(out_data3, 2), 0, 1);
        chk("ch3_zero", int'(out_zero3), 0, 0);
        chk("ch3_lat", lat, LAT3, 0);
        @(negedge clk) out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        chk("ch3_valid_drop", int'(out_valid3), 0, 0);
        out_ready3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
